// File: rtl/sha256_golden_nonce_checker.sv
// Receive side of the hash pipeline: realigns issued nonces with returned hash words,
// flags golden hashes and queues their nonces in a small show-ahead FIFO for the host.
module sha256_golden_nonce_checker #(
  parameter int unsigned LATENCY     = 67,
  parameter logic [31:0] MATCH_VALUE = 32'ha41f32e7,
  parameter int unsigned FIFO_DEPTH  = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] nonce_in,
  input  logic        nonce_valid,
  input  logic [31:0] hash_in,
  output logic [31:0] golden_nonce,
  output logic        golden_valid,
  input  logic        golden_ready,
  output logic        overflow,
  output logic [31:0] match_count
);

  localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(FIFO_DEPTH) + 1;

  logic [LATENCY-1:0] dl_valid_q;
  logic [31:0]        dl_nonce_q [LATENCY];
  logic [31:0]        mem_q [FIFO_DEPTH];

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             overflow_q, overflow_d;
  logic [31:0]      match_count_q, match_count_d;

  logic        d_valid;
  logic [31:0] d_nonce;
  logic        match, full, empty, push, pop;

  // Valid bits are reset so a reset flushes every nonce still in flight.
  // NOTE: sequential state uses non-blocking (<=) so every stage samples the pre-edge value.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      dl_valid_q <= '0;
    end else begin
      dl_valid_q[0] <= nonce_valid;
      for (int i = 1; i < LATENCY; i++) dl_valid_q[i] <= dl_valid_q[i-1];
    end
  end

  // NOTE: data-only storage (nonce delay line, FIFO memory) carries no reset; its validity is
  // tracked by the reset-controlled valid bits and pointers, so resetting it buys nothing.
  always_ff @(posedge clk) begin
    dl_nonce_q[0] <= nonce_in;
    for (int i = 1; i < LATENCY; i++) dl_nonce_q[i] <= dl_nonce_q[i-1];
    if (push) mem_q[wr_ptr_q] <= d_nonce;
  end

  assign d_valid = dl_valid_q[LATENCY-1];
  assign d_nonce = dl_nonce_q[LATENCY-1];
  assign match   = d_valid && (hash_in == MATCH_VALUE);

  assign full  = (count_q == CNT_W'(FIFO_DEPTH));
  assign empty = (count_q == '0);
  assign pop   = !empty && golden_ready;
  // A full FIFO still accepts a push when the head leaves on the same edge.
  assign push  = match && (!full || pop);

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    wr_ptr_d      = wr_ptr_q;
    rd_ptr_d      = rd_ptr_q;
    count_d       = count_q;
    overflow_d    = overflow_q;
    match_count_d = match_count_q;
    if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    count_d = count_q + CNT_W'(push) - CNT_W'(pop);
    if (match) begin
      match_count_d = match_count_q + 32'd1;
      if (!push) overflow_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      count_q       <= '0;
      overflow_q    <= 1'b0;
      match_count_q <= '0;
    end else begin
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      count_q       <= count_d;
      overflow_q    <= overflow_d;
      match_count_q <= match_count_d;
    end
  end

  assign golden_valid = !empty;
  assign golden_nonce = empty ? '0 : mem_q[rd_ptr_q];
  assign overflow     = overflow_q;
  assign match_count  = match_count_q;

endmodule
